// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add dw x dw multiplier sequencing a shared, registered ALU via req/gnt.
// Define ALU_MUL_SEQ_ACC_EN to add port c and compute a*b + c.
module alu_mul_seq #(
    parameter int dw = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [dw-1:0]   a,
    input  logic [dw-1:0]   b,
`ifdef ALU_MUL_SEQ_ACC_EN
    input  logic [dw-1:0]   c,
`endif
    output logic            busy,
    output logic            done,
    output logic [2*dw-1:0] result,
    output logic            alu_req,
    input  logic            alu_gnt,
    output logic [3:0]      alu_op,
    output logic [dw-1:0]   alu_ai,
    output logic [dw-1:0]   alu_bi,
    output logic            alu_ci,
    output logic            alu_right,
    output logic            alu_rotate,
    output logic [3:0]      alu_ei,
    output logic            alu_rdy,
    input  logic [dw-1:0]   alu_out,
    input  logic            alu_co
);
    localparam int cw = $clog2(dw);
    typedef enum logic [1:0] {IDLE, ISSUE, ACC, FIN} state_t;
    state_t            state_q;
    logic [dw-1:0]     m_q, p_q, l_q, p_d, l_d, p_init;
    logic [cw-1:0]     cnt_q;
    logic              busy_q, done_q;
    logic [2*dw-1:0]   result_q;
    logic              issue;
`ifdef ALU_MUL_SEQ_ACC_EN
    assign p_init = c;
`else
    assign p_init = '0;
`endif
    // The ALU carry lands in P's top bit, so the dw+1-bit partial sum is never truncated.
    assign p_d = {alu_co, alu_out[dw-1:1]};
    assign l_d = {alu_out[0], l_q[dw-1:1]};
    assign issue      = state_q == ISSUE;
    assign alu_req    = issue || state_q == ACC;
    assign alu_op     = issue ? 4'b0011 : 4'b1111;
    assign alu_ai     = issue ? p_q : '0;
    assign alu_bi     = (issue && l_q[0]) ? m_q : '0;
    assign alu_ci     = 1'b0;
    assign alu_right  = 1'b0;
    assign alu_rotate = 1'b0;
    assign alu_ei     = 4'b0000;
    assign alu_rdy    = issue && alu_gnt;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            m_q      <= '0;
            p_q      <= '0;
            l_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    m_q     <= a;
                    l_q     <= b;
                    p_q     <= p_init;
                    cnt_q   <= cw'(dw - 1);
                    busy_q  <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: if (alu_gnt) state_q <= ACC;
                ACC: begin
                    p_q <= p_d;
                    l_q <= l_d;
                    if (cnt_q == '0) begin
                        result_q <= {p_d, l_d};
                        done_q   <= 1'b1;
                        state_q  <= FIN;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                        state_q <= ISSUE;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized checks of alu_mul_seq against an arithmetic product model and a registered ALU model.
module tb_alu_mul_seq;
    localparam int DW = 16;
    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, alu_gnt = 1'b1;
    logic [DW-1:0] a = '0, b = '0;
`ifdef ALU_MUL_SEQ_ACC_EN
    logic [DW-1:0] c = '0;
`endif
    logic            busy, done, alu_req, alu_ci, alu_right, alu_rotate, alu_rdy;
    logic [2*DW-1:0] result;
    logic [3:0]      alu_op, alu_ei;
    logic [DW-1:0]   alu_ai, alu_bi;
    logic [DW-1:0]   alu_out = '0;
    logic            alu_co = 1'b0;
    logic [2*DW-1:0] model_res = '0;
    int              checks = 0, errors = 0;

    alu_mul_seq #(.dw(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
`ifdef ALU_MUL_SEQ_ACC_EN
        .c(c),
`endif
        .busy(busy), .done(done), .result(result), .alu_req(alu_req), .alu_gnt(alu_gnt),
        .alu_op(alu_op), .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci), .alu_right(alu_right),
        .alu_rotate(alu_rotate), .alu_ei(alu_ei), .alu_rdy(alu_rdy), .alu_out(alu_out), .alu_co(alu_co)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (alu_rdy) {alu_co, alu_out} <= (DW+1)'(alu_ai) + (DW+1)'(alu_bi) + (DW+1)'(alu_ci);

    task automatic run_mul(input logic [DW-1:0] ma, input logic [DW-1:0] mb, input logic [DW-1:0] mc,
                           input int stall_first, input int gnt_pct, input int restart_at, input string name);
        logic [2*DW-1:0] expv;
        int cyc = 0, stalls = 0, issues = 0;
        bit ok_busy = 1, ok_rdy = 1, ok_hold = 1, got = 0;
        expv = (2*DW)'(ma) * (2*DW)'(mb) + (2*DW)'(mc);
        @(negedge clk);
        a = ma; b = mb; start = 1'b1;
`ifdef ALU_MUL_SEQ_ACC_EN
        c = mc;
`endif
        @(posedge clk);
        @(negedge clk);
        while (cyc < 400) begin
            a = (cyc == restart_at) ? DW'(7) : DW'($urandom);
            b = DW'($urandom);
            start = (cyc == restart_at);
            if (alu_op == 4'b0011) begin
                alu_gnt = (issues < stall_first) ? 1'b0 : ($urandom_range(99) < gnt_pct);
                issues++;
                if (!alu_gnt) stalls++;
            end else alu_gnt = 1'($urandom);
            #1;
            if (alu_rdy !== (alu_op == 4'b0011 && alu_gnt)) ok_rdy = 0;
            if (busy !== 1'b1) ok_busy = 0;
            if (result !== model_res) ok_hold = 0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done === 1'b1) begin got = 1; break; end
        end
        checks++; if (!got) begin errors++; $display("FAIL %s done_seen: got 0 want 1 within 400 cycles", name); end
        checks++; if (cyc != 2*DW + stalls) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, 2*DW + stalls); end
        checks++; if (!ok_rdy) begin errors++; $display("FAIL %s alu_rdy_vs_gnt: got mismatch want rdy==issue&&gnt", name); end
        checks++; if (!ok_busy) begin errors++; $display("FAIL %s busy_during: got low want 1", name); end
        checks++; if (!ok_hold) begin errors++; $display("FAIL %s result_hold_during: got change want %h", name, model_res); end
        checks++; if (result !== expv) begin errors++; $display("FAIL %s result: got %h want %h", name, result, expv); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_in_fin: got %b want 1", name, busy); end
        model_res = expv;
        a = DW'($urandom); b = DW'($urandom); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL %s after_fin busy,done: got %b%b want 00", name, busy, done); end
        checks++; if (result !== model_res) begin errors++; $display("FAIL %s result_hold_after: got %h want %h", name, result, model_res); end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, alu_req, alu_rdy} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, alu_req, alu_rdy}); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (alu_op !== 4'b1111 || alu_ai !== '0 || alu_bi !== '0) begin errors++; $display("FAIL reset_alu: got op %b ai %h bi %h want 1111 0 0", alu_op, alu_ai, alu_bi); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        run_mul(16'd3, 16'd5, '0, 0, 100, -1, "basic_3x5");
        run_mul(16'hFFFF, 16'hFFFF, '0, 0, 100, -1, "max_ffff");
    endtask

    task automatic test_stall;
        run_mul(16'h1234, 16'h0010, '0, 5, 100, -1, "stall5");
    endtask

    task automatic test_restart;
        run_mul(16'd2, 16'd3, '0, 0, 100, 7, "restart_2x3");
        run_mul(16'd7, 16'd7, '0, 0, 100, -1, "after_7x7");
    endtask

    task automatic test_zero;
        run_mul(16'd0, DW'($urandom), '0, 0, 100, -1, "zero_a");
        run_mul(DW'($urandom), 16'd0, '0, 0, 100, -1, "zero_b");
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++)
            run_mul(DW'($urandom), DW'($urandom), '0, 0, 70, int'($urandom_range(40)), "random");
    endtask

    task automatic test_abort;
        run_mul(16'hABCD, 16'h1357, '0, 0, 100, -1, "pre_abort");
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0002; alu_gnt = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_res = '0;
        checks++; if ({busy, done, alu_req} !== 3'b000) begin errors++; $display("FAIL abort_flags: got %b want 000", {busy, done, alu_req}); end
        checks++; if (result !== '0) begin errors++; $display("FAIL abort_result: got %h want 0", result); end
        @(negedge clk);
        reset = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", done); end
        run_mul(16'd2, 16'd2, '0, 0, 100, -1, "post_abort_2x2");
    endtask

`ifdef ALU_MUL_SEQ_ACC_EN
    task automatic test_acc;
        run_mul(16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 100, -1, "acc_ffff");
        for (int i = 0; i < 4; i++)
            run_mul(DW'($urandom), DW'($urandom), DW'($urandom), 0, 80, -1, "acc_random");
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_restart;
        test_zero;
        test_random;
        test_abort;
`ifdef ALU_MUL_SEQ_ACC_EN
        test_acc;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
